// File: rtl/frame_diff_tracker.sv
// rtl/frame_diff_tracker.sv - per-pixel frame difference, motion mask and per-frame motion bounding box
module frame_diff_tracker #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MIN_PIXELS = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iGray1,
  input  logic [11:0] iGray2,
  input  logic        iDVAL,
  input  logic        iSOF,
  input  logic [11:0] iThresh,
  output logic [11:0] oDiff,
  output logic        oMotion,
  output logic        oDVAL,
  output logic [9:0]  oLeft,
  output logic [9:0]  oRight,
  output logic [9:0]  oTop,
  output logic [9:0]  oBottom,
  output logic [18:0] oCount,
  output logic        oBoxValid,
  output logic        oFrameDone
);

  localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - 1);
  localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q;
  logic [9:0]  x_q, y_q;

  logic        s1_valid_q, s1_last_q;
  logic [11:0] s1_diff_q, s1_thresh_q;
  logic [9:0]  s1_x_q, s1_y_q;
  logic        s2_last_q;

  logic [9:0]  min_x_q, max_x_q, min_y_q, max_y_q;
  logic [9:0]  min_x_d, max_x_d, min_y_d, max_y_d;
  logic [18:0] cnt_q, cnt_d;

  logic        accept, abort, px_last, s1_fwd, s1_motion, commit, box_ok;
  logic [9:0]  px_x, px_y;
  logic signed [12:0] diff_s;
  logic [12:0] diff_mag;

  // Pixel acceptance: a start-of-frame pulse forces the current pixel to (0,0)
  always_comb begin
    abort     = iSOF && (state_q == ACTIVE);
    accept    = iDVAL && (iSOF || (state_q == ACTIVE));
    px_x      = iSOF ? 10'd0 : x_q;
    px_y      = iSOF ? 10'd0 : y_q;
    px_last   = (px_x == X_MAX) && (px_y == Y_MAX);
    diff_s    = $signed({1'b0, iGray1}) - $signed({1'b0, iGray2});
    diff_mag  = diff_s[12] ? 13'(-diff_s) : 13'(diff_s);
    s1_fwd    = s1_valid_q && !abort;
    s1_motion = s1_diff_q > s1_thresh_q;
    commit    = s2_last_q;
    box_ok    = cnt_q >= MIN_CNT;
  end

  // Frame scan FSM: tracks raster position and returns to IDLE after the last pixel
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      if (iSOF) begin
        state_q <= ACTIVE;
        x_q     <= '0;
        y_q     <= '0;
      end
      if (accept) begin
        if (px_last) begin
          state_q <= IDLE;
          x_q     <= '0;
          y_q     <= '0;
        end else if (px_x == X_MAX) begin
          x_q <= '0;
          y_q <= px_y + 10'd1;
        end else begin
          x_q <= px_x + 10'd1;
          y_q <= px_y;
        end
      end
    end
  end

  // Stage 1: absolute difference plus the pixel's position, last tag and threshold
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_diff_q   <= '0;
      s1_thresh_q <= '0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q   <= px_last;
        s1_diff_q   <= diff_mag[11:0];
        s1_thresh_q <= iThresh;
        s1_x_q      <= px_x;
        s1_y_q      <= px_y;
      end
    end
  end

  // Stage 2: registered difference and motion flag; an aborting SOF drops the in-flight pixel
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDVAL     <= 1'b0;
      oDiff     <= '0;
      oMotion   <= 1'b0;
      s2_last_q <= 1'b0;
    end else begin
      oDVAL     <= s1_fwd;
      s2_last_q <= s1_fwd && s1_last_q;
      if (s1_fwd) begin
        oDiff   <= s1_diff_q;
        oMotion <= s1_motion;
      end
    end
  end

  // Accumulator next state: re-init on commit/abort first, so a next-frame motion pixel lands in the fresh box
  always_comb begin
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    cnt_d   = cnt_q;
    if (commit || abort) begin
      min_x_d = X_MAX;
      max_x_d = '0;
      min_y_d = Y_MAX;
      max_y_d = '0;
      cnt_d   = '0;
    end
    if (s1_fwd && s1_motion) begin
      if (cnt_d != '1)        cnt_d   = cnt_d + 19'd1;
      if (s1_x_q < min_x_d)   min_x_d = s1_x_q;
      if (s1_x_q > max_x_d)   max_x_d = s1_x_q;
      if (s1_y_q < min_y_d)   min_y_d = s1_y_q;
      if (s1_y_q > max_y_d)   max_y_d = s1_y_q;
    end
  end

  // Accumulator registers
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      min_x_q <= X_MAX;
      max_x_q <= '0;
      min_y_q <= Y_MAX;
      max_y_q <= '0;
      cnt_q   <= '0;
    end else begin
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      cnt_q   <= cnt_d;
    end
  end

  // Commit: publish the finished frame's box and count, held until the next commit
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oFrameDone <= 1'b0;
      oCount     <= '0;
      oBoxValid  <= 1'b0;
      oLeft      <= '0;
      oRight     <= '0;
      oTop       <= '0;
      oBottom    <= '0;
    end else begin
      oFrameDone <= commit;
      if (commit) begin
        oCount    <= cnt_q;
        oBoxValid <= box_ok;
        oLeft     <= box_ok ? min_x_q : 10'd0;
        oRight    <= box_ok ? max_x_q : 10'd0;
        oTop      <= box_ok ? min_y_q : 10'd0;
        oBottom   <= box_ok ? max_y_q : 10'd0;
      end
    end
  end

endmodule

// File: tb/tb_frame_diff_tracker.sv
// tb/tb_frame_diff_tracker.sv - directed self-checking bench for frame_diff_tracker
module tb_frame_diff_tracker;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [11:0] iGray1 = '0, iGray2 = '0, iThresh = '0;
  logic        iDVAL = 1'b0, iSOF = 1'b0;
  logic [11:0] oDiff;
  logic        oMotion, oDVAL, oBoxValid, oFrameDone;
  logic [9:0]  oLeft, oRight, oTop, oBottom;
  logic [18:0] oCount;

  frame_diff_tracker #(.H_ACTIVE(8), .V_ACTIVE(4), .MIN_PIXELS(2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iGray1(iGray1), .iGray2(iGray2),
    .iDVAL(iDVAL), .iSOF(iSOF), .iThresh(iThresh),
    .oDiff(oDiff), .oMotion(oMotion), .oDVAL(oDVAL),
    .oLeft(oLeft), .oRight(oRight), .oTop(oTop), .oBottom(oBottom),
    .oCount(oCount), .oBoxValid(oBoxValid), .oFrameDone(oFrameDone)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dval_cnt = 0, mot_cnt = 0, fd_cnt = 0, fd_cyc = 0, last_drv = 0;
  int mot_diff = 0;

  typedef struct {
    logic [11:0] g1;
    logic [11:0] g2;
    logic [11:0] th;
    int          exp_diff;
    int          exp_mot;
  } vec_t;

  vec_t vecs[7];

  // Output monitor, sampled 2 time units after each rising edge
  always @(posedge iCLK) begin
    #2;
    cyc = cyc + 1;
    if (oDVAL) dval_cnt = dval_cnt + 1;
    if (oDVAL && oMotion) begin
      mot_cnt  = mot_cnt + 1;
      mot_diff = int'(oDiff);
    end
    if (oFrameDone) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    dval_cnt = 0; mot_cnt = 0; fd_cnt = 0; fd_cyc = 0; mot_diff = 0;
  endtask

  task automatic send_pixels(input logic [31:0] mask, input int n, input bit with_sof, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          @(negedge iCLK);
          iDVAL = 1'b0; iSOF = 1'b0;
        end
      end
      @(negedge iCLK);
      iDVAL   = 1'b1;
      iSOF    = with_sof && (i == 0);
      iGray1  = mask[i] ? 12'd900 : 12'd100;
      iGray2  = 12'd100;
      iThresh = 12'd200;
      last_drv = cyc;
    end
    @(negedge iCLK);
    iDVAL = 1'b0; iSOF = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int exp_mot, input int exp_cnt, input int exp_valid,
                             input int l, input int r, input int t, input int b);
    for (int i = 0; i < 20 && fd_cnt == 0; i++) begin
      @(posedge iCLK); #3;
    end
    repeat (4) @(posedge iCLK);
    #3;
    chk({tag, "_framedone_pulses"}, fd_cnt, 1);
    chk({tag, "_framedone_latency"}, fd_cyc - last_drv, 3);
    chk({tag, "_dval_count"}, dval_cnt, 32);
    chk({tag, "_motion_count"}, mot_cnt, exp_mot);
    if (exp_mot > 0) chk({tag, "_motion_diff"}, mot_diff, 800);
    chk({tag, "_count"}, int'(oCount), exp_cnt);
    chk({tag, "_boxvalid"}, int'(oBoxValid), exp_valid);
    chk({tag, "_left"}, int'(oLeft), l);
    chk({tag, "_right"}, int'(oRight), r);
    chk({tag, "_top"}, int'(oTop), t);
    chk({tag, "_bottom"}, int'(oBottom), b);
  endtask

  localparam logic [31:0] MASK2  = (32'd1 << 10) | (32'd1 << 29);
  localparam logic [31:0] MASK1  = (32'd1 << 10);
  localparam logic [31:0] MASK_A = (32'd1 << 10) | (32'd1 << 12);
  localparam logic [31:0] MASK_B = (32'd1 << 6) | (32'd1 << 29);

  initial begin
    vecs[0] = '{12'd10,   12'd4095, 12'd4094, 4085, 0};
    vecs[1] = '{12'd10,   12'd4095, 12'd4084, 4085, 1};
    vecs[2] = '{12'd4095, 12'd10,   12'd4085, 4085, 0};
    vecs[3] = '{12'd900,  12'd100,  12'd200,  800,  1};
    vecs[4] = '{12'd100,  12'd100,  12'd0,    0,    0};
    vecs[5] = '{12'd0,    12'd4095, 12'd0,    4095, 1};
    vecs[6] = '{12'd300,  12'd299,  12'd0,    1,    1};

    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    @(negedge iCLK);
    chk("reset_dval", int'(oDVAL), 0);
    chk("reset_framedone", int'(oFrameDone), 0);
    chk("reset_count", int'(oCount), 0);
    chk("reset_box", int'(oLeft | oRight | oTop | oBottom), 0);
    chk("reset_boxvalid", int'(oBoxValid), 0);
    chk("reset_diff", int'(oDiff) + int'(oMotion), 0);

    // single-pixel vectors, each starting a new (aborted) frame
    clr_mon();
    for (int v = 0; v < 7; v++) begin
      @(negedge iCLK);
      iSOF = 1'b1; iDVAL = 1'b1;
      iGray1 = vecs[v].g1; iGray2 = vecs[v].g2; iThresh = vecs[v].th;
      @(posedge iCLK); #1;
      iSOF = 1'b0; iDVAL = 1'b0;
      @(posedge iCLK); #2;
      chk($sformatf("vec%0d_dval", v), int'(oDVAL), 1);
      chk($sformatf("vec%0d_diff", v), int'(oDiff), vecs[v].exp_diff);
      chk($sformatf("vec%0d_motion", v), int'(oMotion), vecs[v].exp_mot);
    end
    repeat (3) @(posedge iCLK);
    #3;
    chk("vec_no_framedone", fd_cnt, 0);

    // full frame, two motion pixels
    clr_mon();
    send_pixels(MASK2, 32, 1'b1, 1'b0);
    check_frame("two", 2, 2, 1, 2, 5, 1, 3);

    // full frame, one motion pixel: below MIN_PIXELS
    clr_mon();
    send_pixels(MASK1, 32, 1'b1, 1'b0);
    check_frame("one", 1, 1, 0, 0, 0, 0, 0);

    // full frame with random idle gaps
    clr_mon();
    send_pixels(MASK2, 32, 1'b1, 1'b1);
    check_frame("gaps", 2, 2, 1, 2, 5, 1, 3);

    // truncated frame at pixel 20, then a complete frame
    clr_mon();
    send_pixels(MASK_A, 20, 1'b1, 1'b0);
    repeat (4) @(posedge iCLK);
    #3;
    chk("abort_no_framedone", fd_cnt, 0);
    clr_mon();
    send_pixels(MASK_B, 32, 1'b1, 1'b0);
    check_frame("after_abort", 2, 2, 1, 5, 6, 0, 3);

    // reset mid-frame after motion has been seen
    send_pixels(MASK1, 15, 1'b1, 1'b0);
    @(negedge iCLK);
    iRST = 1'b1;
    #1;
    chk("rst_dval", int'(oDVAL), 0);
    chk("rst_count", int'(oCount), 0);
    chk("rst_box", int'(oLeft | oRight | oTop | oBottom), 0);
    chk("rst_boxvalid", int'(oBoxValid), 0);
    chk("rst_diff", int'(oDiff), 0);
    @(negedge iCLK);
    iRST = 1'b0;
    clr_mon();
    send_pixels(MASK2, 8, 1'b0, 1'b0);
    repeat (4) @(posedge iCLK);
    #3;
    chk("rst_no_sof_dval", dval_cnt, 0);
    clr_mon();
    send_pixels(MASK2, 32, 1'b1, 1'b0);
    check_frame("post_rst", 2, 2, 1, 2, 5, 1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_diff_tracker.md
# frame_diff_tracker

Consumes the two buffered gray frames that the memory switch stage splits into alternating frame buffers, read back in lockstep as current/previous pixel pairs. Computes per-pixel absolute difference, thresholds it into a motion mask, and accumulates a per-frame motion bounding box and motion pixel count. The box and count are presented to the overlay/tracking logic once per frame.

## Interface

Parameters:
- H_ACTIVE, 640: active pixels per line (≤1024).
- V_ACTIVE, 480: active lines per frame (≤1024).
- MIN_PIXELS, 16: minimum motion pixel count for a valid box.

Ports:
- iCLK  in  1  pixel clock; all logic on the rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iGray1  in  12  pixel from frame buffer 1.
- iGray2  in  12  co-located pixel from frame buffer 2.
- iDVAL  in  1  iGray1/iGray2 valid this cycle.
- iSOF  in  1  start-of-frame pulse, one cycle.
- iThresh  in  12  motion threshold, sampled per pixel.
- oDiff  out  12  |iGray1 − iGray2| of the pipelined pixel.
- oMotion  out  1  oDiff > iThresh (strict).
- oDVAL  out  1  oDiff/oMotion valid.
- oLeft, oRight, oTop, oBottom  out  10 each  bounding box of the last committed frame.
- oCount  out  19  motion pixel count of the last committed frame; saturates at all-ones.
- oBoxValid  out  1  last committed frame had oCount ≥ MIN_PIXELS.
- oFrameDone  out  1  one-cycle pulse when box/count outputs update.

## Operation

- Reset: all outputs 0. State IDLE. Pipeline valids clear. Accumulators at their init values.
- Accumulator init values: minX = H_ACTIVE−1, maxX = 0, minY = V_ACTIVE−1, maxY = 0, cnt = 0.
- State IDLE:
  - iDVAL without iSOF is ignored; oDVAL stays low.
  - iSOF: go to ACTIVE, set X=0 and Y=0.
  - If iDVAL is also high that cycle, that pixel is (0,0).
- State ACTIVE:
  - Each iDVAL cycle accepts the pixel at (X,Y), then X++.
  - When X = H_ACTIVE−1, X wraps to 0 and Y++.
  - Accepting (H_ACTIVE−1, V_ACTIVE−1) tags that pixel as last and returns to IDLE.
- iSOF while ACTIVE (truncated frame):
  - Clear both pipeline valid bits; in-flight pixels are discarded.
  - Reset the accumulators to their init values.
  - Restart X,Y at 0, stay ACTIVE.
  - No oFrameDone is produced for the aborted frame.
  - The iSOF-cycle pixel (if iDVAL) is accepted as (0,0).
- Stage 1 (registered): diff = |iGray1 − iGray2|.
  - Compute at 13-bit signed width, then take magnitude.
  - Result is 0..4095, no overflow.
  - Registers X, Y, last tag and iThresh alongside the diff.
- Stage 2 (registered):
  - oDiff = diff; oMotion = diff > thresh; oDVAL = stage-1 valid.
  - If motion: cnt = cnt+1 (saturating at 19'h7FFFF).
  - If motion: minX/maxX/minY/maxY updated with min/max of the pixel's X/Y.
- Commit: on the cycle after a last-tagged pixel leaves stage 2:
  - oCount = cnt; oBoxValid = (cnt ≥ MIN_PIXELS).
  - oLeft/oRight/oTop/oBottom = minX/maxX/minY/maxY if valid, else all 0.
  - oFrameDone = 1 for one cycle.
  - Accumulators reset to their init values.
  - Commit takes priority over a simultaneous motion update only if that update belongs to the next frame. That update is applied to the fresh accumulators, not lost.
- Committed outputs hold until the next commit or reset.

## Timing

- Pixel accepted at edge k: oDiff/oMotion/oDVAL valid after edge k+2. Fixed 2-cycle latency, no backpressure.
- Last pixel accepted at edge k: commit at edge k+3; oFrameDone high for exactly one cycle.
- Throughput: one pixel per clock. iDVAL gaps are permitted anywhere; the pipeline advances only on valid data.
- iRST mid-frame: immediate return to reset values. The next frame requires a fresh iSOF.

## Test plan

- Bench with H_ACTIVE=8, V_ACTIVE=4, MIN_PIXELS=2.
  - Stimulus: iSOF+iDVAL, 32 pixels, iGray1=100, iGray2=100, except (2,1)=900 and (5,3)=900 in iGray1; iThresh=200.
  - Response: oMotion high exactly twice with oDiff=800.
  - Response: oFrameDone 3 cycles after the last pixel; oLeft=2, oRight=5, oTop=1, oBottom=3, oCount=2, oBoxValid=1.
- Same frame with only one motion pixel.
  - Response: oCount=1, oBoxValid=0, all box outputs 0.
- iGray2 > iGray1 (iGray1=10, iGray2=4095), iThresh=4094.
  - Response: oDiff=4085, oMotion=0.
  - With iThresh=4084: oMotion=1.
  - Equal-to-threshold case (oDiff = iThresh): oMotion=0.
- Random iDVAL gaps (≈50% duty) through a full frame.
  - Response: identical box/count to the gap-free run; oDVAL count = 32.
- iSOF at pixel 20 of a frame, then a complete frame.
  - Response: no oFrameDone for the aborted frame.
  - The following frame's box reflects only its own pixels.
- iRST asserted mid-frame with motion already seen.
  - Response: all outputs 0 immediately.
  - Pixels without iSOF ignored (oDVAL stays 0).
  - The next iSOF frame commits correctly.
